display_14seg_mux: RTL and testbench
====================================

// Module: display_14seg_mux
// PURPOSE
//  Multiplexed driver for a DIGITS-position 14-segment display with decimal points.
//  Holds a per-digit character buffer (ASCII) with blink/DP attributes and scans one digit per slot.
//  Inserts a blanking gap between digits to prevent ghosting, and applies output polarities.
//  Sits between a CPU/UART register interface and the display pins; replaces the single-digit decoder.
// PARAMETERS
//  DIGITS            4      number of digit positions, >=2
//  SCAN_DIV          25000  clock cycles per digit slot, > BLANK_CYCLES
//  BLANK_CYCLES      16     cycles at start of each slot with all outputs inactive, >=1
//  BLINK_DIV         64     full frames per blink half-period, >=1
//  COMMON_CATHODE    1      1: segment active high; 0: segment/DP outputs inverted
//  DIGIT_ACTIVE_HIGH 1      1: selected Digit_o bit high; 0: low
// PORTS
//  Clock       in   1        system clock, rising edge
//  Reset       in   1        asynchronous, active-high
//  Enable_i    in   1        0 forces all display outputs inactive; scanning continues
//  Write_i     in   1        buffer write strobe, one entry per cycle
//  Address_i   in   AW       digit index, AW=$clog2(DIGITS); index 0 is Digit_o[0]
//  Data_i      in   8        ASCII code
//  Attr_i      in   2        {blink, dp} attributes for the written digit
//  Segments_o  out  14       segment drive, polarity per COMMON_CATHODE
//  Dp_o        out  1        decimal point drive, polarity per COMMON_CATHODE
//  Digit_o     out  DIGITS   one-hot digit select, polarity per DIGIT_ACTIVE_HIGH
//  FrameStart_o out 1        one-cycle pulse at the start of each digit-0 slot
// BEHAVIOUR
//  Reset (async): buffer = 8'h20 (space) all digits, attrs = 0, state BLANK, index 0,
//   slot counter 0, frame counter 0, blink phase 0 (visible). Outputs inactive:
//   Digit_o all inactive, Segments_o/Dp_o off-level, FrameStart_o=0.
//  All outputs registered. Slot = SCAN_DIV cycles: BLANK for BLANK_CYCLES, then SHOW.
//  FSM: BLANK -> SHOW when slot counter == BLANK_CYCLES-1. SHOW -> BLANK at SCAN_DIV-1;
//   index increments, wraps DIGITS-1 -> 0.
//  FrameStart_o: high on the first BLANK cycle of digit 0, including the first after reset.
//  Glyph and attr for the current index are sampled on the edge entering SHOW.
//   They are held for the whole slot, so a mid-slot write never tears the display.
//  Write: on a rising edge with Write_i=1, buffer[Address_i] <= Data_i and attr[Address_i] <= Attr_i.
//   Address_i >= DIGITS: the write is ignored.
//   A write on the same edge as SHOW entry for that digit: the old value is shown.
//   The new value appears in the next frame.
//  Decode: ASCII 0x61..0x7A fold to 0x41..0x5A before lookup. Codes with no glyph give blank (all 0).
//  Blink: the frame counter counts completed frames and toggles the blink phase every BLINK_DIV frames.
//   When phase=1, digits with the blink attr show blank segments and DP. Digit_o is still driven.
//  Enable_i=0: from the next edge, Digit_o, Segments_o and Dp_o are inactive.
//   Counters, FSM and FrameStart_o continue. Re-enable resumes at the current slot position.
//  Polarity: inversion is applied last, on the register inputs.
// STRUCTURE
//  Package display_pkg: state encodings ST_BLANK/ST_SHOW, GLYPH_BLANK=14'h0000, ASCII_SPACE=8'h20.
//  Sub-module ascii_14seg_rom: combinational 8-bit ASCII -> 14-bit active-high glyph, team glyph table.
//  Top level holds the buffer, counters, FSM and output registers.
// TESTING  (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_DIV=2 unless noted)
//  1 Release reset -> 2 cycles with Digit_o=0000, then Digit_o=0001 for 6 cycles, Segments_o=0.
//    Reset asserted mid-SHOW -> outputs inactive immediately, no clock needed.
//  2 Write 0x30 @0, 0x41 @1, 0x61 @2 -> digit0 shows 14'b00000000111111.
//    Digits 1 and 2 both show 14'b00010001110111.
//  3 Free run -> Digit_o sequence 0001,0010,0100,1000, each active 6 of 8 cycles.
//    Frame period 32 cycles; FrameStart_o pulses once per 32 cycles.
//  4 Attr {1,1} @2 -> digit2 segments + Dp_o lit in frames 0-1, blank in frames 2-3, then repeats.
//    Dp_o lit only in digit2 slots.
//  5 Write digit1 mid-slot during its SHOW -> current slot unchanged, new glyph shown next frame.
//    DIGITS=5: write to Address_i=6 -> no buffer change.
//  6 COMMON_CATHODE=0, DIGIT_ACTIVE_HIGH=0 -> idle Segments_o=14'h3FFF, Digit_o=11111.
//    Enable_i=0 mid-slot -> inactive on the next cycle, FrameStart_o cadence unchanged.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the multiplexed 14-segment display driver.
package display_pkg;

    localparam int unsigned SEG_W = 14;

    // Scan FSM: leading blanking gap, then the digit is driven for the rest of the slot.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Per-digit attributes as written on Attr_i.
    typedef struct packed {
        logic blink;
        logic dp;
    } attr_t;

    localparam logic [SEG_W-1:0] GLYPH_BLANK = 14'h0000;
    localparam logic [7:0]       ASCII_SPACE = 8'h20;

    // Segment bit positions (active-high). H/J/K/M are the diagonals,
    // I/L the upper/lower centre verticals, G1/G2 the split middle bar.
    localparam logic [SEG_W-1:0] SEG_A  = 14'h0001;  // top
    localparam logic [SEG_W-1:0] SEG_B  = 14'h0002;  // upper right
    localparam logic [SEG_W-1:0] SEG_C  = 14'h0004;  // lower right
    localparam logic [SEG_W-1:0] SEG_D  = 14'h0008;  // bottom
    localparam logic [SEG_W-1:0] SEG_E  = 14'h0010;  // lower left
    localparam logic [SEG_W-1:0] SEG_F  = 14'h0020;  // upper left
    localparam logic [SEG_W-1:0] SEG_G1 = 14'h0040;  // middle left
    localparam logic [SEG_W-1:0] SEG_H  = 14'h0080;  // diagonal upper left
    localparam logic [SEG_W-1:0] SEG_I  = 14'h0100;  // centre upper
    localparam logic [SEG_W-1:0] SEG_J  = 14'h0200;  // diagonal upper right
    localparam logic [SEG_W-1:0] SEG_G2 = 14'h0400;  // middle right
    localparam logic [SEG_W-1:0] SEG_K  = 14'h0800;  // diagonal lower left
    localparam logic [SEG_W-1:0] SEG_L  = 14'h1000;  // centre lower
    localparam logic [SEG_W-1:0] SEG_M  = 14'h2000;  // diagonal lower right

    // Fold lower-case ASCII onto upper case so the glyph table only needs one set.
    function automatic logic [7:0] fold_case(input logic [7:0] code);
        if ((code >= 8'h61) && (code <= 8'h7A)) begin
            return code - 8'h20;
        end
        return code;
    endfunction

endpackage

// File: rtl/ascii_14seg_rom.sv
// ASCII to 14-segment glyph table (active-high). Unlisted codes decode to blank.
module ascii_14seg_rom
    import display_pkg::*;
(
    input  logic [7:0]       code,
    output logic [SEG_W-1:0] glyph_c
);

    // Glyph lookup; expects upper-case letters.
    always_comb begin
        glyph_c = GLYPH_BLANK;
        case (code)
            8'h20: glyph_c = GLYPH_BLANK;
            8'h2A: glyph_c = SEG_G1 | SEG_G2 | SEG_H | SEG_I | SEG_J | SEG_K | SEG_L | SEG_M;
            8'h2B: glyph_c = SEG_G1 | SEG_G2 | SEG_I | SEG_L;
            8'h2D: glyph_c = SEG_G1 | SEG_G2;
            8'h2F: glyph_c = SEG_J | SEG_K;
            8'h30: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            8'h31: glyph_c = SEG_B | SEG_C;
            8'h32: glyph_c = SEG_A | SEG_B | SEG_G1 | SEG_G2 | SEG_E | SEG_D;
            8'h33: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G2;
            8'h34: glyph_c = SEG_F | SEG_G1 | SEG_G2 | SEG_B | SEG_C;
            8'h35: glyph_c = SEG_A | SEG_F | SEG_G1 | SEG_G2 | SEG_C | SEG_D;
            8'h36: glyph_c = SEG_A | SEG_F | SEG_E | SEG_D | SEG_C | SEG_G1 | SEG_G2;
            8'h37: glyph_c = SEG_A | SEG_B | SEG_C;
            8'h38: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G1 | SEG_G2;
            8'h39: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G1 | SEG_G2;
            8'h3C: glyph_c = SEG_J | SEG_M;
            8'h3D: glyph_c = SEG_D | SEG_G1 | SEG_G2;
            8'h3E: glyph_c = SEG_H | SEG_K;
            8'h3F: glyph_c = SEG_A | SEG_B | SEG_G2 | SEG_L;
            8'h41: glyph_c = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G1 | SEG_G2;
            8'h42: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G2 | SEG_I | SEG_L;
            8'h43: glyph_c = SEG_A | SEG_D | SEG_E | SEG_F;
            8'h44: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_I | SEG_L;
            8'h45: glyph_c = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G1;
            8'h46: glyph_c = SEG_A | SEG_E | SEG_F | SEG_G1;
            8'h47: glyph_c = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G2;
            8'h48: glyph_c = SEG_B | SEG_C | SEG_E | SEG_F | SEG_G1 | SEG_G2;
            8'h49: glyph_c = SEG_A | SEG_D | SEG_I | SEG_L;
            8'h4A: glyph_c = SEG_B | SEG_C | SEG_D | SEG_E;
            8'h4B: glyph_c = SEG_E | SEG_F | SEG_G1 | SEG_J | SEG_M;
            8'h4C: glyph_c = SEG_D | SEG_E | SEG_F;
            8'h4D: glyph_c = SEG_B | SEG_C | SEG_E | SEG_F | SEG_H | SEG_J;
            8'h4E: glyph_c = SEG_B | SEG_C | SEG_E | SEG_F | SEG_H | SEG_M;
            8'h4F: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            8'h50: glyph_c = SEG_A | SEG_B | SEG_E | SEG_F | SEG_G1 | SEG_G2;
            8'h51: glyph_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_M;
            8'h52: glyph_c = SEG_A | SEG_B | SEG_E | SEG_F | SEG_G1 | SEG_G2 | SEG_M;
            8'h53: glyph_c = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G1 | SEG_G2;
            8'h54: glyph_c = SEG_A | SEG_I | SEG_L;
            8'h55: glyph_c = SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            8'h56: glyph_c = SEG_E | SEG_F | SEG_K | SEG_J;
            8'h57: glyph_c = SEG_B | SEG_C | SEG_E | SEG_F | SEG_K | SEG_M;
            8'h58: glyph_c = SEG_H | SEG_J | SEG_K | SEG_M;
            8'h59: glyph_c = SEG_H | SEG_J | SEG_L;
            8'h5A: glyph_c = SEG_A | SEG_D | SEG_J | SEG_K;
            8'h5F: glyph_c = SEG_D;
            default: glyph_c = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/display_14seg_mux.sv
// Multiplexed DIGITS-position 14-segment driver: character buffer, slot scan with
// blanking gap, blink/DP attributes and output polarity.
module display_14seg_mux
    import display_pkg::*;
#(
    parameter int unsigned DIGITS            = 4,
    parameter int unsigned SCAN_DIV          = 25000,
    parameter int unsigned BLANK_CYCLES      = 16,
    parameter int unsigned BLINK_DIV         = 64,
    parameter bit          COMMON_CATHODE    = 1'b1,
    parameter bit          DIGIT_ACTIVE_HIGH = 1'b1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Enable_i,
    input  logic                        Write_i,
    input  logic [$clog2(DIGITS)-1:0]   Address_i,
    input  logic [7:0]                  Data_i,
    input  logic [1:0]                  Attr_i,
    output logic [SEG_W-1:0]            Segments_o,
    output logic                        Dp_o,
    output logic [DIGITS-1:0]           Digit_o,
    output logic                        FrameStart_o
);

    localparam int unsigned AW = $clog2(DIGITS);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Off-levels double as XOR masks: the active-high value XOR off-level gives the pin value.
    localparam logic [SEG_W-1:0]  SEG_OFF = COMMON_CATHODE ? {SEG_W{1'b0}} : {SEG_W{1'b1}};
    localparam logic              DP_OFF  = ~COMMON_CATHODE;
    localparam logic [DIGITS-1:0] DIG_OFF = DIGIT_ACTIVE_HIGH ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

    logic [7:0]       buffer [DIGITS];
    attr_t            attr   [DIGITS];

    scan_state_e      state;
    logic [CW-1:0]    slot_cnt;
    logic [AW-1:0]    index;
    logic [FW-1:0]    frame_cnt;
    logic             blink_phase;

    logic [SEG_W-1:0] glyph_q;
    logic             dp_q;
    logic             hide_q;

    logic             slot_end_c;
    logic             blank_end_c;
    logic             last_digit_c;
    logic             frame_end_c;
    logic [7:0]       rom_code_c;
    logic [SEG_W-1:0] rom_glyph_c;

    logic             lit_c;
    logic [SEG_W-1:0] seg_c;
    logic             dp_c;
    logic [DIGITS-1:0] dig_c;
    logic             frame_start_c;

    assign slot_end_c   = (slot_cnt == CW'(SCAN_DIV - 1));
    assign blank_end_c  = (slot_cnt == CW'(BLANK_CYCLES - 1));
    assign last_digit_c = (index == AW'(DIGITS - 1));
    assign frame_end_c  = slot_end_c && last_digit_c;
    assign rom_code_c   = fold_case(buffer[index]);

    ascii_14seg_rom u_rom (
        .code    (rom_code_c),
        .glyph_c (rom_glyph_c)
    );

    // Character/attribute buffer; out-of-range addresses are dropped.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                buffer[AW'(i)] <= ASCII_SPACE;
                attr[AW'(i)]   <= '0;
            end
        end else if (Write_i && (32'(Address_i) < DIGITS)) begin
            buffer[Address_i] <= Data_i;
            attr[Address_i]   <= attr_t'(Attr_i);
        end
    end

    // Scan FSM, slot/frame counters and per-slot glyph capture on SHOW entry.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= ST_BLANK;
            slot_cnt    <= '0;
            index       <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            glyph_q     <= GLYPH_BLANK;
            dp_q        <= 1'b0;
            hide_q      <= 1'b0;
        end else begin
            slot_cnt <= slot_end_c ? '0 : slot_cnt + CW'(1);
            case (state)
                ST_BLANK: begin
                    if (blank_end_c) begin
                        state   <= ST_SHOW;
                        glyph_q <= rom_glyph_c;
                        dp_q    <= attr[index].dp;
                        hide_q  <= attr[index].blink & blink_phase;
                    end
                end
                ST_SHOW: begin
                    if (slot_end_c) begin
                        state <= ST_BLANK;
                        index <= last_digit_c ? '0 : index + AW'(1);
                    end
                end
                default: state <= ST_BLANK;
            endcase
            if (frame_end_c) begin
                if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    // Active-high drive values for the current slot position.
    always_comb begin
        lit_c         = (state == ST_SHOW) && Enable_i;
        seg_c         = GLYPH_BLANK;
        dp_c          = 1'b0;
        dig_c         = '0;
        frame_start_c = (state == ST_BLANK) && (slot_cnt == '0) && (index == '0);
        if (lit_c) begin
            dig_c = DIGITS'(1) << index;
            if (!hide_q) begin
                seg_c = glyph_q;
                dp_c  = dp_q;
            end
        end
    end

    // Output registers with polarity applied on the way in.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Segments_o   <= SEG_OFF;
            Dp_o         <= DP_OFF;
            Digit_o      <= DIG_OFF;
            FrameStart_o <= 1'b0;
        end else begin
            Segments_o   <= seg_c ^ SEG_OFF;
            Dp_o         <= dp_c ^ DP_OFF;
            Digit_o      <= dig_c ^ DIG_OFF;
            FrameStart_o <= frame_start_c;
        end
    end

endmodule

// File: tb/tb_display_14seg_mux.sv
// Directed bench: a 4-digit common-cathode instance and a 5-digit inverted-polarity
// instance run side by side from one reset; outputs are checked every cycle.
module tb_display_14seg_mux;

    logic        Clock;
    logic        Reset;

    logic        a_en, a_wr;
    logic [1:0]  a_addr;
    logic [7:0]  a_data;
    logic [1:0]  a_attr;
    logic [13:0] a_seg;
    logic        a_dp;
    logic [3:0]  a_dig;
    logic        a_fs;

    logic        b_en, b_wr;
    logic [2:0]  b_addr;
    logic [7:0]  b_data;
    logic [1:0]  b_attr;
    logic [13:0] b_seg;
    logic        b_dp;
    logic [4:0]  b_dig;
    logic        b_fs;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;

    // Expected lit glyph of the 4-digit instance per frame (rows 0..4, frame 5 repeats row 4).
    logic [13:0] a_tbl [5][4];

    display_14seg_mux #(
        .DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(2),
        .COMMON_CATHODE(1'b1), .DIGIT_ACTIVE_HIGH(1'b1)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .Enable_i(a_en), .Write_i(a_wr),
        .Address_i(a_addr), .Data_i(a_data), .Attr_i(a_attr),
        .Segments_o(a_seg), .Dp_o(a_dp), .Digit_o(a_dig), .FrameStart_o(a_fs)
    );

    display_14seg_mux #(
        .DIGITS(5), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(2),
        .COMMON_CATHODE(1'b0), .DIGIT_ACTIVE_HIGH(1'b0)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .Enable_i(b_en), .Write_i(b_wr),
        .Address_i(b_addr), .Data_i(b_data), .Attr_i(b_attr),
        .Segments_o(b_seg), .Dp_o(b_dp), .Digit_o(b_dig), .FrameStart_o(b_fs)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", tag, k, got, exp);
        end
    endtask

    // Interval k shows the slot position k-1 (one register stage); interval 0 is post-reset.
    task automatic check_cycle();
        logic        live, show_a, show_b, en_b;
        int          p, d, ob, db;
        logic [2:0]  fi;
        logic [1:0]  di;
        logic [3:0]  e_dig_a;
        logic [13:0] e_seg_a;
        logic        e_dp_a;
        logic [4:0]  e_dig_b;
        logic [13:0] e_seg_b;
        live = (k > 0);
        p    = live ? k - 1 : 0;
        d    = (p % 32) / 8;
        fi   = 3'((p / 32) > 4 ? 4 : (p / 32));
        di   = 2'(d);
        show_a  = live && ((p % 8) >= 2);
        e_dig_a = show_a ? 4'(4'b0001 << d) : 4'b0000;
        e_seg_a = show_a ? a_tbl[fi][di] : 14'h0000;
        e_dp_a  = show_a && (d == 2) && (fi == 3'd1 || fi == 3'd4);
        check("a_digit", 32'(a_dig), 32'(e_dig_a));
        check("a_segments", 32'(a_seg), 32'(e_seg_a));
        check("a_dp", 32'(a_dp), 32'(e_dp_a));
        check("a_framestart", 32'(a_fs), 32'(live && (p % 32 == 0)));

        ob      = p % 40;
        db      = ob / 8;
        en_b    = !(k >= 100 && k <= 110);
        show_b  = live && ((ob % 8) >= 2) && en_b;
        e_dig_b = show_b ? 5'(~(5'b00001 << db)) : 5'b11111;
        e_seg_b = (show_b && db == 4) ? 14'h3B88 : 14'h3FFF;
        check("b_digit", 32'(b_dig), 32'(e_dig_b));
        check("b_segments", 32'(b_seg), 32'(e_seg_b));
        check("b_dp", 32'(b_dp), 32'(1'b1));
        check("b_framestart", 32'(b_fs), 32'(live && ob == 0));
    endtask

    task automatic a_write(input logic [1:0] ad, input logic [7:0] dt, input logic [1:0] at);
        a_wr = 1'b1; a_addr = ad; a_data = dt; a_attr = at;
    endtask

    task automatic b_write(input logic [2:0] ad, input logic [7:0] dt, input logic [1:0] at);
        b_wr = 1'b1; b_addr = ad; b_data = dt; b_attr = at;
    endtask

    // Inputs for the rising edge number e.
    task automatic drive(input int e);
        a_wr = 1'b0;
        b_wr = 1'b0;
        case (e)
            3:  b_write(3'd4, 8'h41, 2'b00);   // 'A' on the fifth digit
            4:  b_write(3'd6, 8'h30, 2'b11);   // out of range, dropped
            25: a_write(2'd0, 8'h30, 2'b00);   // '0'
            26: a_write(2'd1, 8'h41, 2'b00);   // 'A'
            27: a_write(2'd2, 8'h61, 2'b11);   // 'a', blink + dp
            44: a_write(2'd1, 8'h30, 2'b00);   // mid-SHOW of digit 1, frame 1
            58: a_write(2'd3, 8'h41, 2'b00);   // same edge as digit 3 SHOW entry
            70: a_write(2'd0, 8'h01, 2'b00);   // no glyph for 0x01
            default: ;
        endcase
        b_en = !(e >= 100 && e <= 110);
    endtask

    initial begin
        a_tbl = '{
            '{14'h0000, 14'h0000, 14'h0000, 14'h0000},
            '{14'h003F, 14'h0477, 14'h0477, 14'h0000},
            '{14'h003F, 14'h003F, 14'h0000, 14'h0477},
            '{14'h0000, 14'h003F, 14'h0000, 14'h0477},
            '{14'h0000, 14'h003F, 14'h0477, 14'h0477}
        };
        Reset  = 1'b1;
        a_en   = 1'b1; a_wr = 1'b0; a_addr = '0; a_data = '0; a_attr = '0;
        b_en   = 1'b1; b_wr = 1'b0; b_addr = '0; b_data = '0; b_attr = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i <= 174; i++) begin
            k = i;
            if (i == 0) #1;
            else @(negedge Clock);
            check_cycle();
            drive(i + 1);
        end

        // Asynchronous reset in the middle of a lit SHOW slot.
        #1 Reset = 1'b1;
        #1;
        check("rst_a_digit", 32'(a_dig), 32'(4'b0000));
        check("rst_a_segments", 32'(a_seg), 32'(14'h0000));
        check("rst_a_dp", 32'(a_dp), 32'(1'b0));
        check("rst_a_framestart", 32'(a_fs), 32'(1'b0));
        check("rst_b_digit", 32'(b_dig), 32'(5'b11111));
        check("rst_b_segments", 32'(b_seg), 32'(14'h3FFF));
        check("rst_b_dp", 32'(b_dp), 32'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
